reorder_buffer: RTL

- 16-entry circular reorder buffer that retires instructions in program order.
- Sits between issue/rename and the architectural register file.
- Allocates a 4-bit rename tag per instruction, captures results from the CDB, and marks entries ready from the register file's simple-instruction path.
- Commits one entry per cycle into the register file; on a mispredicted branch at the head it raises a flush to the register file, RS and fetch.

---
 rtl/reorder_buffer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates rename tags, collects CDB/simple results,
// and retires one entry per cycle in program order, flushing on a mispredicted branch.
module reorder_buffer #(
    parameter int ROB_SIZE = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        alloc_valid,
    input  logic [4:0]  alloc_rd,
    input  logic        alloc_is_branch,
    input  logic        alloc_pred_taken,
    output logic [3:0]  alloc_rename,
    output logic        rob_full,
    input  logic        simple_ins_commit,
    input  logic [3:0]  simple_ins_rename,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_rename,
    input  logic [31:0] cdb_value,
    input  logic        cdb_branch_taken,
    input  logic [31:0] cdb_branch_target,
    output logic        register_update_flag,
    output logic [4:0]  register_commit_dest,
    output logic [31:0] register_commit_value,
    output logic [3:0]  rename_of_commit_ins,
    output logic        rob_flush,
    output logic [31:0] flush_pc
);

    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_ready;
    logic [4:0]          r_rd          [ROB_SIZE];
    logic [31:0]         r_value       [ROB_SIZE];
    logic                r_isBranch    [ROB_SIZE];
    logic                r_predTaken   [ROB_SIZE];
    logic                r_actualTaken [ROB_SIZE];
    logic [31:0]         r_target      [ROB_SIZE];

    logic [3:0] r_head;
    logic [3:0] r_tail;
    logic [4:0] r_count;

    logic w_commit;
    logic w_mispredict;
    logic w_alloc;
    logic w_cdbWrite;
    logic w_simpleWrite;

    assign rob_full     = (r_count == 5'(ROB_SIZE));
    assign alloc_rename = r_tail;

    // Commit looks only at pre-edge ready bits, so a result arriving this cycle retires next cycle.
    assign w_commit      = rdy && (r_count != 5'd0) && r_valid[r_head] && r_ready[r_head];
    assign w_mispredict  = w_commit && r_isBranch[r_head]
                           && (r_actualTaken[r_head] != r_predTaken[r_head]);
    assign w_alloc       = rdy && alloc_valid && !rob_full && !w_mispredict;
    assign w_cdbWrite    = rdy && cdb_valid && r_valid[cdb_rename];
    assign w_simpleWrite = rdy && simple_ins_commit && r_valid[simple_ins_rename];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid               <= '0;
            r_ready               <= '0;
            r_head                <= 4'd0;
            r_tail                <= 4'd0;
            r_count               <= 5'd0;
            register_update_flag  <= 1'b0;
            register_commit_dest  <= 5'd0;
            register_commit_value <= 32'd0;
            rename_of_commit_ins  <= 4'd0;
            rob_flush             <= 1'b0;
            flush_pc              <= 32'd0;
        end else begin
            register_update_flag <= 1'b0;
            rob_flush            <= 1'b0;
            if (rdy) begin
                if (w_cdbWrite) begin
                    r_ready[cdb_rename] <= 1'b1;
                end
                if (w_simpleWrite) begin
                    r_ready[simple_ins_rename] <= 1'b1;
                end
                if (w_commit) begin
                    r_valid[r_head]       <= 1'b0;
                    r_head                <= r_head + 4'd1;
                    rename_of_commit_ins  <= r_head;
                    register_commit_dest  <= r_rd[r_head];
                    register_commit_value <= r_value[r_head];
                    register_update_flag  <= !r_isBranch[r_head] && (r_rd[r_head] != 5'd0);
                end
                // A mispredict discards every younger entry, including any allocation this cycle.
                if (w_mispredict) begin
                    rob_flush <= 1'b1;
                    flush_pc  <= r_target[r_head];
                    r_valid   <= '0;
                    r_head    <= 4'd0;
                    r_tail    <= 4'd0;
                    r_count   <= 5'd0;
                end else begin
                    if (w_alloc) begin
                        r_valid[r_tail] <= 1'b1;
                        r_ready[r_tail] <= 1'b0;
                        r_tail          <= r_tail + 4'd1;
                    end
                    r_count <= r_count + 5'(w_alloc) - 5'(w_commit);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_rd[r_tail]        <= alloc_rd;
            r_isBranch[r_tail]  <= alloc_is_branch;
            r_predTaken[r_tail] <= alloc_pred_taken;
        end
        if (w_cdbWrite) begin
            r_value[cdb_rename]       <= cdb_value;
            r_actualTaken[cdb_rename] <= cdb_branch_taken;
            r_target[cdb_rename]      <= cdb_branch_target;
        end
    end

endmodule
